// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - mdu_op_e   : 4-bit operation code driven on the op port
//   - mdu_state_e: FSM encoding (IDLE / BUSY)
//   - default latencies for multiply and divide
//   - is_arith() : true for the ops that occupy the unit for several cycles
package mdu_pkg;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_arith(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational datapath of the multiply/divide unit.
//   a_i, b_i    : latched operands
//   op_i        : latched operation
//   result_o    : {hi, lo} result (product, or {remainder, quotient})
//   div_zero_o  : divide op with a zero divisor; result must not be committed
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  mdu_op_e     op_i,
    output logic [63:0] result_o,
    output logic        div_zero_o
);

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, q_res, r_res;
    logic [63:0] a_ext, b_ext;

    always_comb begin
        result_o   = 64'd0;
        div_zero_o = 1'b0;

        // Sign extension of both operands makes the low 64 bits of the
        // product the correct signed result; zero extension gives unsigned.
        a_ext = (op_i == MDU_MULT) ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
        b_ext = (op_i == MDU_MULT) ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};

        // Signed divide works on magnitudes so 0x80000000 / -1 wraps to
        // 0x80000000 instead of overflowing.
        a_neg = (op_i == MDU_DIV) && a_i[31];
        b_neg = (op_i == MDU_DIV) && b_i[31];
        a_mag = a_neg ? (~a_i + 32'd1) : a_i;
        b_mag = b_neg ? (~b_i + 32'd1) : b_i;
        q_mag = 32'd0;
        r_mag = 32'd0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        q_res = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        r_res = a_neg ? (~r_mag + 32'd1) : r_mag;

        case (op_i)
            MDU_MULT, MDU_MULTU: result_o = a_ext * b_ext;
            MDU_DIV, MDU_DIVU: begin
                result_o   = {r_res, q_res};
                div_zero_o = (b_i == 32'd0);
            end
            default: result_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with architectural HI/LO.
//   clk, reset       : clock, async active-high reset
//   start, op        : operation request, sampled on the rising edge
//   A, B             : operands (rs, rt)
//   busy             : arithmetic op in flight (registered)
//   HI, LO           : architectural HI/LO registers
//   rd_data          : combinational MFHI/MFLO read port
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepts arithmetic starts and MTHI/MTLO writes
// ST_BUSY | counting down latency; all starts ignored; commit at cnt=1
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] rd_data
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    mdu_op_e          op_q, op_d;
    logic             busy_q, busy_d;
    mdu_op_e          op_in;
    logic [63:0]      result;
    logic             div_zero;

    assign op_in = mdu_op_e'(op);

    mdu_arith u_arith (
        .a_i        (a_q),
        .b_i        (b_q),
        .op_i       (op_q),
        .result_o   (result),
        .div_zero_o (div_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= MDU_NONE;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_arith(op_in)) begin
                        a_d     = A;
                        b_d     = B;
                        op_d    = op_in;
                        cnt_d   = (op_in == MDU_DIV || op_in == MDU_DIVU)
                                  ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_d = ST_BUSY;
                        busy_d  = 1'b1;
                    end else if (op_in == MDU_MTHI) begin
                        hi_d = A;
                    end else if (op_in == MDU_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (!div_zero) begin
                        hi_d = result[63:32];
                        lo_d = result[31:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data = 32'd0;
        if (op_in == MDU_MFHI) rd_data = hi_q;
        else if (op_in == MDU_MFLO) rd_data = lo_q;
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
    import mdu_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk, reset, start, busy;
    logic [3:0]  op;
    logic [31:0] A, B, HI, LO, rd_data;

    int tests  = 0;
    int failed = 0;
    logic [31:0] m_hi = 0, m_lo = 0;

    mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .HI(HI), .LO(LO), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            MDU_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            MDU_MULTU: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            MDU_DIV:   if (b != 0) begin
                           q = sa / sb; r = sa % sb;
                           p = q; m_lo = p[31:0];
                           p = r; m_hi = p[31:0];
                       end
            MDU_DIVU:  if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            default: ;
        endcase
    endtask

    // Issue one arithmetic op, measure busy length, check HI/LO.
    task automatic do_arith(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        int exp_n;
        exp_n = (o == MDU_DIV || o == MDU_DIVU) ? ND : NM;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = MDU_NONE; A = $urandom; B = $urandom;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        model(o, a, b);
        check({tag, "_busy_cycles"}, n, exp_n);
        check({tag, "_hi"}, HI, m_hi);
        check({tag, "_lo"}, LO, m_lo);
    endtask

    task automatic do_mt(input logic [3:0] o, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; op = o; A = a;
        @(negedge clk);
        start = 1'b0; op = MDU_NONE;
        if (o == MDU_MTHI) begin m_hi = a; check("mthi", HI, m_hi); end
        else begin m_lo = a; check("mtlo", LO, m_lo); end
    endtask

    initial begin
        int n;
        logic [3:0] ops[4];
        ops[0] = MDU_MULT; ops[1] = MDU_MULTU; ops[2] = MDU_DIV; ops[3] = MDU_DIVU;
        reset = 1'b1; start = 1'b0; op = MDU_NONE; A = 0; B = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);

        do_arith("mult", MDU_MULT, 32'hFFFFFFFF, 32'd2);
        check("mult_hi_lit", HI, 32'hFFFFFFFF);
        do_arith("multu", MDU_MULTU, 32'hFFFFFFFF, 32'd2);
        check("multu_hi_lit", HI, 32'h00000001);
        do_arith("div", MDU_DIV, 32'hFFFFFFF9, 32'd2);
        check("div_lo_lit", LO, 32'hFFFFFFFD);
        do_arith("divu", MDU_DIVU, 32'd7, 32'd2);
        do_arith("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_lo_lit", LO, 32'h80000000);

        do_mt(MDU_MTHI, 32'h55);
        do_mt(MDU_MTLO, 32'h55);
        do_arith("div0", MDU_DIV, 32'd5, 32'd0);
        check("div0_hi_lit", HI, 32'h55);

        do_mt(MDU_MTLO, 32'h1234);
        op = MDU_MFLO; #1;
        check("rd_mflo", rd_data, 32'h1234);
        op = MDU_MFHI; #1;
        check("rd_mfhi", rd_data, m_hi);
        op = MDU_NONE; #1;
        check("rd_none", rd_data, 32'd0);

        // Starts during BUSY must be ignored.
        @(negedge clk);
        start = 1'b1; op = MDU_MULT; A = 32'd6; B = 32'd7;
        @(negedge clk);
        op = MDU_MTHI; A = 32'hAA;
        n = 1;
        @(negedge clk);
        op = MDU_MULT; A = 32'd100; B = 32'd100;
        n++;
        @(negedge clk);
        start = 1'b0; op = MDU_MFHI; #1;
        check("rd_while_busy", rd_data, m_hi);
        n++;
        while (busy && n < 200) begin
            @(negedge clk);
            if (busy) n++;
        end
        op = MDU_NONE;
        model(MDU_MULT, 32'd6, 32'd7);
        check("ign_busy_cycles", n, NM);
        check("ign_hi", HI, m_hi);
        check("ign_lo", LO, m_lo);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            logic [3:0] ro;
            ro = ops[$urandom_range(0, 3)];
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000000F;
            if ($urandom_range(0, 5) == 0) do_mt(($urandom_range(0, 1) == 0) ? MDU_MTHI : MDU_MTLO, $urandom);
            do_arith("rand", ro, ra, rb);
        end

        // Asynchronous reset in the middle of a divide.
        do_mt(MDU_MTHI, 32'h77);
        @(negedge clk);
        start = 1'b1; op = MDU_DIV; A = 32'd100; B = 32'd3;
        @(negedge clk);
        start = 1'b0; op = MDU_NONE;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
        repeat (ND + 2) @(negedge clk);
        check("post_rst_hi", HI, 32'd0);
        check("post_rst_lo", LO, 32'd0);
        do_arith("post_rst_multu", MDU_MULTU, 32'd3, 32'd4);
        check("post_rst_lo_lit", LO, 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
